register_file: RTL and testbench
================================

Name: register_file

Overview:
- RV32I integer register file: 32 registers x 32 bits, x0 hardwired to zero.
- Two combinational read ports (rs1/rs2) and one synchronous write port (rd).
- Sits in the core datapath between decode (register indices) and execute/writeback (operands, result).

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of register index ports.
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset; clears all registers.
- write  input  1  write enable for the write port.
- rd  input  5  destination register index.
- reg_write  input  32  data written to register rd.
- rs1  input  5  read-port-1 register index.
- rs2  input  5  read-port-2 register index.
- reg1  output  32  contents of register rs1 (combinational).
- reg2  output  32  contents of register rs2 (combinational).

Behaviour:
- Storage: NUM_REGS x DATA_WIDTH flops.
- Reset:
  - rst low clears all registers to 0 immediately, independent of clk.
  - reg1 and reg2 therefore read 0 during reset.
  - Writes are ignored while rst is low.
- Write:
  - On a clk rising edge with rst high, write=1 and rd!=0: reg[rd] <= reg_write.
  - New value is visible on the read ports after that edge (1-cycle write latency).
  - write=0 leaves all registers unchanged.
- x0:
  - Writes with rd=0 are discarded.
  - Reads of index 0 always return 0.
  - x0 need not be implemented as a flop.
- Read:
  - reg1 = reg[rs1] and reg2 = reg[rs2], purely combinational, no clock latency.
  - Both ports may address the same register simultaneously; both return the same value.
- No write-to-read bypass:
  - A read of rd in the same cycle as its write returns the old value until the clock edge.
  - After the edge, it returns the new value.
- Reset mid-operation:
  - Asserting rst aborts any pending write.
  - After rst deasserts, the next rising edge with write=1 writes normally.
  - A write held asserted across the reset release takes effect at the first edge after release.
- Registers hold their values indefinitely between writes.
- No X propagation from unwritten registers, since all are cleared by reset.

Decomposition:
- Shared package:
  - DATA_WIDTH and ADDR_WIDTH constants.
  - typedefs: word_t (logic [31:0]) and reg_idx_t (logic [4:0]), for reuse by decode/ALU/writeback.
- No sub-module required.
- Write-decode and read-mux logic stay inline in register_file.

Test Plan:
- Reset: write x1=0x1 and x2=0x1, then pulse rst low for one cycle with write deasserted → reg1 (rs1=1) = 0 and reg2 (rs2=2) = 0.
- Write/read port 1: write=1, rd=1, reg_write=0x1, rs1=1, rs2=0; after one posedge → reg1=0x1, reg2=0.
- Write/read port 2: write=1, rd=1, reg_write=0x1, rs1=0, rs2=1; after one posedge → reg1=0, reg2=0x1.
- x0 protection: write=1, rd=0, reg_write=0xDEADBEEF, rs1=0, rs2=0 → reg1=reg2=0 after the edge.
- Idle after reset: write=0, rs1=1, rs2=1, wait 2 cycles → reg1=reg2=0; all 32 registers read 0.
- No bypass and async reset:
  - write=1, rd=5, reg_write=0x12345678, rs1=5 → reg1 = old value before the edge, 0x12345678 after it.
  - Drop rst between clock edges → reg1=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared register-file types and widths.
// Reused by decode, ALU and writeback stages.
package register_file_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/register_file.sv
// RV32I integer register file, x0 tied to zero.
// Two combinational read ports, one synchronous write port.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = register_file_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] reg_write,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0] reg1,
  output logic [DATA_WIDTH-1:0] reg2
);

  // x0 has no storage; index 0 falls through to the zero default
  logic [DATA_WIDTH-1:0] regs [NUM_REGS-1:1];
  logic [NUM_REGS-1:1]   we;

  always_comb begin
    we = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      we[i] = write && (rd == i[ADDR_WIDTH-1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (we[i]) begin
          regs[i] <= reg_write;
        end
      end
    end
  end

  always_comb begin
    reg1 = '0;
    reg2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs1 == i[ADDR_WIDTH-1:0]) begin
        reg1 = regs[i];
      end
      if (rs2 == i[ADDR_WIDTH-1:0]) begin
        reg2 = regs[i];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        write;
  logic [4:0]  rd;
  logic [31:0] reg_write;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] reg1;
  logic [31:0] reg2;

  int total = 0;
  int bad   = 0;

  register_file dut (
    .clk       (clk),
    .rst       (rst),
    .write     (write),
    .rd        (rd),
    .reg_write (reg_write),
    .rs1       (rs1),
    .rs2       (rs2),
    .reg1      (reg1),
    .reg2      (reg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    write     = 1'b0;
    rd        = '0;
    reg_write = '0;
    rs1       = '0;
    rs2       = '0;
    #2;
    for (int i = 0; i < 32; i++) begin
      rs1 = i[4:0];
      rs2 = 5'(31 - i);
      #1;
      chk("rst_r1", reg1, 32'h0);
      chk("rst_r2", reg2, 32'h0);
    end
    step();
    rst = 1'b1;

    // seed x1, x2 then pulse reset
    write = 1'b1; rd = 5'd1; reg_write = 32'h1;
    step();
    rd = 5'd2;
    step();
    write = 1'b0; rs1 = 5'd1; rs2 = 5'd2;
    #1;
    chk("seed_x1", reg1, 32'h1);
    chk("seed_x2", reg2, 32'h1);
    rst = 1'b0;
    step();
    chk("pulse_x1", reg1, 32'h0);
    chk("pulse_x2", reg2, 32'h0);
    rst = 1'b1;

    // idle after reset: all zero
    step();
    step();
    for (int i = 0; i < 32; i++) begin
      rs1 = i[4:0];
      rs2 = i[4:0];
      #1;
      chk("idle_r1", reg1, 32'h0);
      chk("idle_r2", reg2, 32'h0);
    end

    // port 1
    write = 1'b1; rd = 5'd1; reg_write = 32'h1;
    rs1 = 5'd1; rs2 = 5'd0;
    #1;
    chk("p1_pre", reg1, 32'h0);
    step();
    chk("p1_r1", reg1, 32'h1);
    chk("p1_r2", reg2, 32'h0);

    // port 2
    rs1 = 5'd0; rs2 = 5'd1;
    step();
    chk("p2_r1", reg1, 32'h0);
    chk("p2_r2", reg2, 32'h1);

    // x0 protection
    rd = 5'd0; reg_write = 32'hDEADBEEF;
    rs1 = 5'd0; rs2 = 5'd0;
    step();
    chk("x0_r1", reg1, 32'h0);
    chk("x0_r2", reg2, 32'h0);

    // write disabled holds state
    write = 1'b0; rd = 5'd1; reg_write = 32'hFFFF_FFFF;
    rs1 = 5'd1;
    step();
    step();
    chk("hold_x1", reg1, 32'h1);

    // distinct regs, boundary x31
    write = 1'b1; rd = 5'd31; reg_write = 32'hA5A5A5A5;
    step();
    rd = 5'd30; reg_write = 32'h5A5A5A5A;
    step();
    write = 1'b0; rs1 = 5'd31; rs2 = 5'd30;
    #1;
    chk("x31", reg1, 32'hA5A5A5A5);
    chk("x30", reg2, 32'h5A5A5A5A);

    // no bypass, then same reg on both ports
    write = 1'b1; rd = 5'd5; reg_write = 32'h12345678;
    rs1 = 5'd5; rs2 = 5'd5;
    #1;
    chk("nobyp_pre", reg1, 32'h0);
    step();
    chk("nobyp_r1", reg1, 32'h12345678);
    chk("nobyp_r2", reg2, 32'h12345678);
    write = 1'b0;
    reg_write = 32'h0BAD0BAD;
    step();
    rd = 5'd5; write = 1'b1; reg_write = 32'hCAFEF00D;
    #1;
    chk("overwr_pre", reg1, 32'h12345678);
    step();
    chk("overwr", reg1, 32'hCAFEF00D);

    // async reset between edges, write held across release
    rd = 5'd7; reg_write = 32'h00000077; write = 1'b0;
    rs1 = 5'd5; rs2 = 5'd31;
    #2;
    rst = 1'b0;
    #1;
    chk("async_r1", reg1, 32'h0);
    chk("async_r2", reg2, 32'h0);
    write = 1'b1; rs1 = 5'd7;
    step();
    chk("rst_blk_wr", reg1, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("rel_noedge", reg1, 32'h0);
    step();
    chk("rel_wr", reg1, 32'h00000077);
    write = 1'b0; rs2 = 5'd5;
    #1;
    chk("rel_x5", reg2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
